tap_reader_n: RTL and testbench

//   Read side of the FIR sample delay line. Stores the last N_TAPS input samples in a circular buffer.
//   For each accepted sample it streams the taps x[n], x[n-1], ..., x[n-N_TAPS+1] one per handshake.
//   The consumer is the serial MAC, which pairs tap_index with its coefficient.

---
 rtl/tap_reader_n_if.sv | 29 ++
 rtl/tap_reader_n.sv | 127 ++++++++++++
 tb/tb_tap_reader_n.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/tap_reader_n_if.sv
// Handshake bundle between the sample source / serial MAC and tap_reader_n.
//   in_valid/in_ready/data_in         : sample input stream
//   tap_valid/tap_ready/tap_data/
//   tap_index/tap_last                : serial tap output stream
// master: drives samples and tap_ready (source + MAC side)
// slave : the delay-line reader itself
interface tap_reader_n_if #(
  parameter int unsigned LOG2_TAPS  = 4,
  parameter int unsigned WIDTH_DATA = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH_DATA-1:0] data_in;
  logic                  tap_valid;
  logic                  tap_ready;
  logic [WIDTH_DATA-1:0] tap_data;
  logic [LOG2_TAPS-1:0]  tap_index;
  logic                  tap_last;

  modport master (
    output in_valid, data_in, tap_ready,
    input  in_ready, tap_valid, tap_data, tap_index, tap_last
  );

  modport slave (
    input  in_valid, data_in, tap_ready,
    output in_ready, tap_valid, tap_data, tap_index, tap_last
  );
endinterface

// File: rtl/tap_reader_n.sv
// Read side of the FIR sample delay line.
// Keeps the last N_TAPS samples in a circular buffer and, for every accepted
// sample, streams x[n], x[n-1], ... x[n-N_TAPS+1] one per tap handshake.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   enable : global clock enable; low freezes every register
//   bus    : tap_reader_n_if.slave (sample input + tap output handshakes)
module tap_reader_n #(
  parameter int unsigned N_TAPS     = 16,
  parameter int unsigned LOG2_TAPS  = 4,
  parameter int unsigned WIDTH_DATA = 8
) (
  input logic           clk,
  input logic           reset,
  input logic           enable,
  tap_reader_n_if.slave bus
);

  typedef logic [LOG2_TAPS-1:0]  ptr_t;
  typedef logic [WIDTH_DATA-1:0] data_t;
  typedef enum logic {IDLE, READ} state_t;

  localparam ptr_t LAST_IDX = ptr_t'(N_TAPS - 1);
  localparam ptr_t ONE      = ptr_t'(1);

  data_t  mem [N_TAPS];
  state_t state_q, state_d;
  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   base_q, base_d;
  ptr_t   idx_q, idx_d;
  data_t  tap_data_q, tap_data_d;
  logic   tap_valid_q, tap_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   tap_last_q, tap_last_d;

  logic   accept;
  logic   handshake;
  ptr_t   rd_addr;

  assign accept    = enable && bus.in_valid && in_ready_q;
  assign handshake = enable && tap_valid_q && bus.tap_ready;
  // Next tap is one sample older than the current one; pointer width wraps mod N_TAPS.
  assign rd_addr   = base_q - idx_q - ONE;

  assign bus.in_ready  = in_ready_q;
  assign bus.tap_valid = tap_valid_q;
  assign bus.tap_data  = tap_data_q;
  assign bus.tap_index = idx_q;
  assign bus.tap_last  = tap_last_q;

  // Sample buffer: cleared on reset so history older than the first
  // N_TAPS samples reads as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_TAPS; i++) mem[i] <= '0;
    end else if (accept) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      base_q      <= '0;
      idx_q       <= '0;
      tap_data_q  <= '0;
      tap_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      tap_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      tap_data_q  <= tap_data_d;
      tap_valid_q <= tap_valid_d;
      in_ready_q  <= in_ready_d;
      tap_last_q  <= tap_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    base_d      = base_q;
    idx_d       = idx_q;
    tap_data_d  = tap_data_q;
    tap_valid_d = tap_valid_q;
    in_ready_d  = in_ready_q;
    tap_last_d  = tap_last_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // Tap 0 comes straight from the input, no buffer read needed.
          base_d      = wr_ptr_q;
          wr_ptr_d    = wr_ptr_q + ONE;
          tap_data_d  = bus.data_in;
          idx_d       = '0;
          tap_valid_d = 1'b1;
          in_ready_d  = 1'b0;
          tap_last_d  = (LAST_IDX == '0);
          state_d     = READ;
        end
      end
      READ: begin
        if (handshake) begin
          if (idx_q == LAST_IDX) begin
            tap_valid_d = 1'b0;
            idx_d       = '0;
            in_ready_d  = 1'b1;
            tap_last_d  = 1'b0;
            state_d     = IDLE;
          end else begin
            tap_data_d  = mem[rd_addr];
            idx_d       = idx_q + ONE;
            tap_last_d  = ((idx_q + ONE) == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tap_reader_n.sv
// Scoreboard bench for tap_reader_n. The reference model keeps a plain list of
// past samples (newest first) and, per accepted sample, queues the N_TAPS taps
// that sample should produce. A monitor compares DUT outputs to the queue head
// every falling edge and pops on each tap handshake.
module tb_tap_reader_n;
  localparam int N  = 16;
  localparam int LG = 4;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  always #5 clk = ~clk;

  tap_reader_n_if #(.LOG2_TAPS(LG), .WIDTH_DATA(W)) bus ();

  tap_reader_n #(.N_TAPS(N), .LOG2_TAPS(LG), .WIDTH_DATA(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  typedef struct {
    int data;
    int idx;
    int last;
  } tap_t;

  tap_t exp_q[$];
  int   hist[$];
  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 0;
  int   cyc = 0;
  int   last_acc = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: tap k of a new sample is the k-th most recent sample, zero if
  // fewer than k+1 samples have arrived since reset.
  function automatic void model_accept(input int d);
    tap_t t;
    hist.push_front(d);
    if (hist.size() > N) void'(hist.pop_back());
    for (int k = 0; k < N; k++) begin
      t.data = (k < hist.size()) ? hist[k] : 0;
      t.idx  = k;
      t.last = (k == N - 1) ? 1 : 0;
      exp_q.push_back(t);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // tap_ready generator: 0 = always ready, 1 = fixed stall pattern, 2 = random
  initial begin
    logic [5:0] pat;
    int ph;
    pat = 6'b101001;
    ph = 0;
    bus.tap_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.tap_ready = 1'b1;
        1: begin
          bus.tap_ready = pat[ph % 6];
          ph++;
        end
        default: bus.tap_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("rst_tap_valid", int'(bus.tap_valid), 0);
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_tap_data", int'(bus.tap_data), 0);
      chk("rst_tap_index", int'(bus.tap_index), 0);
      chk("rst_tap_last", int'(bus.tap_last), 0);
    end else begin
      chk("in_ready", int'(bus.in_ready), int'(exp_q.size() == 0));
      chk("tap_valid", int'(bus.tap_valid), int'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("tap_data", int'(bus.tap_data), exp_q[0].data);
        chk("tap_index", int'(bus.tap_index), exp_q[0].idx);
        chk("tap_last", int'(bus.tap_last), exp_q[0].last);
        if (enable && bus.tap_ready) void'(exp_q.pop_front());
      end else begin
        chk("idle_tap_index", int'(bus.tap_index), 0);
        chk("idle_tap_last", int'(bus.tap_last), 0);
      end
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic send(input int d, input bit garb, input bit chk_gap);
    int n;
    bit go;
    n = 0;
    go = 1'b0;
    bus.in_valid = 1'b1;
    forever begin
      go = enable && bus.in_ready;
      bus.data_in = (go || !garb) ? W'(d) : W'($urandom);
      @(posedge clk);
      #1;
      if (go) break;
      n++;
      if (n > 200) break;
    end
    chk("send_accepted", int'(go), 1);
    if (go) begin
      model_accept(d & 8'hFF);
      if (chk_gap) chk("accept_gap", cyc - last_acc, N + 1);
      last_acc = cyc;
    end
    bus.in_valid = garb;
    if (garb) bus.data_in = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", int'(n < 500), 1);
  endtask

  task automatic wait_idx(input int target);
    int n;
    n = 0;
    while (!(bus.tap_valid && int'(bus.tap_index) == target) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_idx_found", int'(n < 200), 1);
  endtask

  initial begin
    // T1: reset held with a live sample on the input
    reset = 1'b0;
    enable = 1'b1;
    bus.in_valid = 1'b1;
    bus.data_in = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_in_ready", int'(bus.in_ready), 1);
    chk("t1_tap_valid", int'(bus.tap_valid), 0);
    chk("t1_tap_data", int'(bus.tap_data), 0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    send(32'h11, 1'b0, 1'b0);
    drain();

    // T2: back-to-back samples with tap_ready=1, pointer wraps
    rdy_mode = 0;
    for (int v = 1; v <= 20; v++) send(v, 1'b0, v > 1);
    bus.in_valid = 1'b0;
    drain();

    // T3: stall pattern on tap_ready
    rdy_mode = 1;
    for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 255)), 1'b0, 1'b0);
    drain();

    // T4: in_valid held high with changing data while busy
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 255)), 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    drain();

    // T5: clock-enable freeze at tap 6
    rdy_mode = 0;
    send(int'($urandom_range(0, 255)), 1'b0, 1'b0);
    wait_idx(6);
    enable = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("t5_frozen_index", int'(bus.tap_index), 6);
    chk("t5_frozen_valid", int'(bus.tap_valid), 1);
    enable = 1'b1;
    drain();

    // T6: asynchronous reset mid-stream
    send(int'($urandom_range(0, 255)), 1'b0, 1'b0);
    wait_idx(7);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_tap_valid", int'(bus.tap_valid), 0);
    chk("t6_async_tap_index", int'(bus.tap_index), 0);
    chk("t6_async_tap_data", int'(bus.tap_data), 0);
    chk("t6_async_in_ready", int'(bus.in_ready), 1);
    exp_q.delete();
    hist.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(32'h5A, 1'b0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
